// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear scaler core.
package bilinear_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DIV,
    ST_SETUP,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_FETCH3,
    ST_CAPT,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int unsigned FLOPS_PER_PIXEL = 10;
  localparam int unsigned SCALE_MIN_Q88   = 128;
  localparam int unsigned SCALE_MAX_Q88   = 256;

  function automatic logic [8:0] clamp_scale(input logic [15:0] s);
    if (s < 16'(SCALE_MIN_Q88)) return 9'(SCALE_MIN_Q88);
    if (s > 16'(SCALE_MAX_Q88)) return 9'(SCALE_MAX_Q88);
    return s[8:0];
  endfunction

endpackage

// File: rtl/bilinear_seq_core_if.sv
// BRAM-side bundle of the scaler: input-image read port and output-image write port.
interface bilinear_seq_core_if #(
  parameter int unsigned AW = 12
) ();
  logic [AW-1:0] in_raddr;
  logic [7:0]    in_rdata;
  logic [AW-1:0] out_waddr;
  logic [7:0]    out_wdata;
  logic          out_we;

  modport master (output in_raddr, input in_rdata, output out_waddr, output out_wdata, output out_we);
  modport slave  (input in_raddr, output in_rdata, input out_waddr, input out_wdata, input out_we);
endinterface

// File: rtl/bilinear_seq_core_div.sv
// seq_div: 17-bit unsigned restoring divider, one quotient bit per cycle.
module seq_div (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [16:0] dividend_i,
  input  logic [16:0] divisor_i,
  output logic [16:0] quotient_o,
  output logic        done_o
);
  logic [16:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [17:0] rem_sh;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    rem_sh = {rem_q, quo_q[16]};
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = 5'd17;
    end else if (cnt_q != 5'd0) begin
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = 17'(rem_sh - {1'b0, dvs_q});
        quo_d = {quo_q[15:0], 1'b1};
      end else begin
        rem_d = rem_sh[16:0];
        quo_d = {quo_q[15:0], 1'b0};
      end
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  // done marks the cycle of the final step; quotient is complete on the next cycle
  assign done_o     = (cnt_q == 5'd1);
  assign quotient_o = quo_q;
endmodule

// File: rtl/bilinear_seq_core.sv
// Bilinear image scaler: per output pixel, four BRAM fetches, interpolate, one write.
// Performance counters exist only when BILINEAR_PERF_EN is defined.
module bilinear_seq_core
  import bilinear_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  input  logic                  start_pulse,
  input  logic [15:0]           cfg_in_w,
  input  logic [15:0]           cfg_in_h,
  input  logic [15:0]           cfg_scale_q88,
  output logic                  status_done,
  output logic                  status_busy,
  output logic [31:0]           perf_flops,
  output logic [31:0]           perf_mem_rd,
  output logic [31:0]           perf_mem_wr,
  bilinear_seq_core_if.master   bram
);
  state_t        state_q, state_d;
  logic          start_prev_q, accept_start, div_start, div_done;
  logic [15:0]   in_w_q, in_w_d, in_h_q, in_h_d, out_w_q, out_w_d, out_h_q, out_h_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [8:0]    scale_q, scale_d;
  logic [7:0]    p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [16:0]   inv_q88;

  seq_div u_div (
    .clk_i      (clk_sys),
    .rst_i      (rst_sys),
    .start_i    (div_start),
    .dividend_i (17'h10000),
    .divisor_i  ({8'b0, clamp_scale(cfg_scale_q88)}),
    .quotient_o (inv_q88),
    .done_o     (div_done)
  );

  // Source coordinates of the current output pixel
  logic [23:0] sx, sy;
  logic [15:0] w_m1, h_m1, xi, x1, yi, y1, row, col, ow_raw, oh_raw;
  logic [16:0] xi_p1, yi_p1;
  logic [7:0]  fx, fy;
  assign sx    = 24'(x_q) * 24'(inv_q88);
  assign sy    = 24'(y_q) * 24'(inv_q88);
  assign fx    = sx[7:0];
  assign fy    = sy[7:0];
  assign w_m1  = in_w_q - 16'd1;
  assign h_m1  = in_h_q - 16'd1;
  assign xi    = (sx[23:8] > w_m1) ? w_m1 : sx[23:8];
  assign yi    = (sy[23:8] > h_m1) ? h_m1 : sy[23:8];
  assign xi_p1 = {1'b0, sx[23:8]} + 17'd1;
  assign yi_p1 = {1'b0, sy[23:8]} + 17'd1;
  assign x1    = (xi_p1 > {1'b0, w_m1}) ? w_m1 : xi_p1[15:0];
  assign y1    = (yi_p1 > {1'b0, h_m1}) ? h_m1 : yi_p1[15:0];
  assign row   = (state_q == ST_FETCH2 || state_q == ST_FETCH3) ? y1 : yi;
  assign col   = (state_q == ST_FETCH1 || state_q == ST_FETCH3) ? x1 : xi;
  assign ow_raw = 16'((25'(in_w_q) * 25'(scale_q)) >> 8);
  assign oh_raw = 16'((25'(in_h_q) * 25'(scale_q)) >> 8);

  logic [25:0] h0, h1, acc;
  logic [9:0]  pix_w;
  logic [7:0]  pix;
  assign h0    = 26'(p00_q) * (26'd256 - 26'(fx)) + 26'(p01_q) * 26'(fx);
  assign h1    = 26'(p10_q) * (26'd256 - 26'(fx)) + 26'(p11_q) * 26'(fx);
  assign acc   = h0 * (26'd256 - 26'(fy)) + h1 * 26'(fy) + 26'd32768;
  assign pix_w = 10'(acc >> 16);
  assign pix   = (pix_w > 10'd255) ? 8'hFF : pix_w[7:0];

  assign accept_start = start_pulse && !start_prev_q && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    in_w_d    = in_w_q;
    in_h_d    = in_h_q;
    scale_d   = scale_q;
    out_w_d   = out_w_q;
    out_h_d   = out_h_q;
    x_d       = x_q;
    y_d       = y_q;
    p00_d     = p00_q;
    p01_d     = p01_q;
    p10_d     = p10_q;
    p11_d     = p11_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept_start) begin
        state_d   = ST_DIV;
        div_start = 1'b1;
        in_w_d    = cfg_in_w;
        in_h_d    = cfg_in_h;
        scale_d   = clamp_scale(cfg_scale_q88);
        x_d       = '0;
        y_d       = '0;
      end
      ST_DIV:   if (div_done) state_d = ST_SETUP;
      ST_SETUP: begin
        out_w_d = (ow_raw == 16'd0) ? 16'd1 : ow_raw;
        out_h_d = (oh_raw == 16'd0) ? 16'd1 : oh_raw;
        state_d = (in_w_q == 16'd0 || in_h_q == 16'd0) ? ST_DONE : ST_FETCH0;
      end
      // BRAM data lags the address by one cycle, so each capture trails its fetch
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: begin p00_d = bram.in_rdata; state_d = ST_FETCH2; end
      ST_FETCH2: begin p01_d = bram.in_rdata; state_d = ST_FETCH3; end
      ST_FETCH3: begin p10_d = bram.in_rdata; state_d = ST_CAPT;   end
      ST_CAPT:   begin p11_d = bram.in_rdata; state_d = ST_CALC;   end
      ST_CALC: begin
        wdata_d = pix;
        waddr_d = AW'(y_q) * AW'(out_w_q) + AW'(x_q);
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_FETCH0;
        if (x_q == out_w_q - 16'd1) begin
          x_d = '0;
          if (y_q == out_h_q - 16'd1) state_d = ST_DONE;
          else                        y_d = y_q + 16'd1;
        end else begin
          x_d = x_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      in_w_q       <= '0;
      in_h_q       <= '0;
      scale_q      <= '0;
      out_w_q      <= '0;
      out_h_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      p00_q        <= '0;
      p01_q        <= '0;
      p10_q        <= '0;
      p11_q        <= '0;
      wdata_q      <= '0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_pulse;
      in_w_q       <= in_w_d;
      in_h_q       <= in_h_d;
      scale_q      <= scale_d;
      out_w_q      <= out_w_d;
      out_h_q      <= out_h_d;
      x_q          <= x_d;
      y_q          <= y_d;
      p00_q        <= p00_d;
      p01_q        <= p01_d;
      p10_q        <= p10_d;
      p11_q        <= p11_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
    end
  end

  assign bram.in_raddr  = (state_q inside {ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_FETCH3})
                          ? AW'(row) * AW'(in_w_q) + AW'(col) : '0;
  assign bram.out_waddr = waddr_q;
  assign bram.out_wdata = wdata_q;
  // Gated by reset so a write in flight is suppressed in the reset cycle itself
  assign bram.out_we    = (state_q == ST_WRITE) && !rst_sys;
  assign status_done    = (state_q == ST_DONE);
  assign status_busy    = !(state_q inside {ST_IDLE, ST_DONE});

`ifdef BILINEAR_PERF_EN
  logic [31:0] flops_q, flops_d, rd_q, rd_d, wr_q, wr_d;
  always_comb begin
    flops_d = flops_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (accept_start) begin
      flops_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else if (state_q == ST_WRITE) begin
      flops_d = flops_q + 32'(FLOPS_PER_PIXEL);
      rd_d    = rd_q + 32'd4;
      wr_d    = wr_q + 32'd1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      flops_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      flops_q <= flops_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  assign perf_flops  = flops_q;
  assign perf_mem_rd = rd_q;
  assign perf_mem_wr = wr_q;
`else
  assign perf_flops  = '0;
  assign perf_mem_rd = '0;
  assign perf_mem_wr = '0;
`endif
endmodule

// File: tb/tb_bilinear_seq_core.sv
// Directed self-checking bench for bilinear_seq_core; counter expectations follow BILINEAR_PERF_EN.
module tb_bilinear_seq_core;
  localparam int unsigned AW = 12;
`ifdef BILINEAR_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        start_pulse = 1'b0;
  logic [15:0] cfg_in_w = '0, cfg_in_h = '0, cfg_scale_q88 = '0;
  logic        status_done, status_busy;
  logic [31:0] perf_flops, perf_mem_rd, perf_mem_wr;

  bilinear_seq_core_if #(.AW(AW)) bif ();

  bilinear_seq_core #(.AW(AW)) dut (
    .clk_sys       (clk_sys),
    .rst_sys       (rst_sys),
    .start_pulse   (start_pulse),
    .cfg_in_w      (cfg_in_w),
    .cfg_in_h      (cfg_in_h),
    .cfg_scale_q88 (cfg_scale_q88),
    .status_done   (status_done),
    .status_busy   (status_busy),
    .perf_flops    (perf_flops),
    .perf_mem_rd   (perf_mem_rd),
    .perf_mem_wr   (perf_mem_wr),
    .bram          (bif)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) bif.in_rdata <= mem[bif.in_raddr];

  int unsigned   n_cmp = 0, n_err = 0;
  int unsigned   wr_cnt = 0, busy_cnt = 0, base_wr = 0, base_busy = 0;
  logic [AW-1:0] wr_addr [0:255];
  logic [7:0]    wr_data [0:255];

  always @(negedge clk_sys) begin
    if (bif.out_we === 1'b1) begin
      wr_addr[wr_cnt[7:0]] <= bif.out_waddr;
      wr_data[wr_cnt[7:0]] <= bif.out_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (status_busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int unsigned k, input logic [31:0] a, input logic [7:0] d);
    int unsigned idx;
    idx = (base_wr + k) & 32'd255;
    chk($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[idx]), a);
    chk($sformatf("%s_data%0d", tag, k), 32'(wr_data[idx]), 32'(d));
  endtask

  task automatic chk_perf(input string tag, input int unsigned npix);
    chk({tag, "_flops"}, perf_flops,  PERF ? 32'(10 * npix) : 32'd0);
    chk({tag, "_rd"},    perf_mem_rd, PERF ? 32'(4 * npix)  : 32'd0);
    chk({tag, "_wr"},    perf_mem_wr, PERF ? 32'(npix)      : 32'd0);
  endtask

  task automatic kick(input logic [15:0] w, input logic [15:0] h, input logic [15:0] s);
    base_wr       = wr_cnt;
    base_busy     = busy_cnt;
    cfg_in_w      = w;
    cfg_in_h      = h;
    cfg_scale_q88 = s;
    start_pulse   = 1'b1;
    tick(1);
    start_pulse   = 1'b0;
    cfg_in_w      = 16'd7;
    cfg_in_h      = 16'd9;
    cfg_scale_q88 = 16'h0080;
  endtask

  task automatic run(input string tag, input logic [15:0] w, input logic [15:0] h,
                     input logic [15:0] s, input bit restart);
    kick(w, h, s);
    for (int i = 0; i < 600 && status_done !== 1'b1; i++) begin
      if (restart && i == 40) start_pulse = 1'b1;
      if (restart && i == 43) start_pulse = 1'b0;
      tick(1);
    end
    start_pulse = 1'b0;
    tick(1);
    chk({tag, "_done"}, 32'(status_done), 32'd1);
    chk({tag, "_busy"}, 32'(status_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    tick(3);
    chk("rst_done",  32'(status_done), 32'd0);
    chk("rst_busy",  32'(status_busy), 32'd0);
    chk("rst_flops", perf_flops, 32'd0);
    chk("rst_rd",    perf_mem_rd, 32'd0);
    chk("rst_wr",    perf_mem_wr, 32'd0);
    chk("rst_raddr", 32'(bif.in_raddr), 32'd0);
    chk("rst_waddr", 32'(bif.out_waddr), 32'd0);
    chk("rst_wdata", 32'(bif.out_wdata), 32'd0);
    chk("rst_we",    32'(bif.out_we), 32'd0);
    rst_sys = 1'b0;
    tick(2);
    chk("idle_busy", 32'(status_busy), 32'd0);

    // Identity scale on a ramp
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 10 + 3);
    run("s1", 16'd4, 16'd4, 16'h0100, 1'b0);
    chk("s1_nwr", wr_cnt - base_wr, 32'd16);
    chk("s1_cycles", busy_cnt - base_busy, 32'd130);
    for (int k = 0; k < 16; k++) chk_wr("s1", k, 32'(k), mem[k]);
    chk_perf("s1", 16);

    // Half scale picks every other source pixel
    run("s2", 16'd4, 16'd4, 16'h0080, 1'b0);
    chk("s2_nwr", wr_cnt - base_wr, 32'd4);
    for (int k = 0; k < 4; k++) chk_wr("s2", k, 32'(k), mem[(k / 2) * 8 + (k % 2) * 2]);
    chk_perf("s2", 4);

    // Scale below range clamps to 0x80; above range clamps to 0x100
    run("s2lo", 16'd4, 16'd4, 16'h0040, 1'b0);
    chk("s2lo_nwr", wr_cnt - base_wr, 32'd4);
    chk_wr("s2lo", 1, 32'd1, mem[2]);
    run("s2hi", 16'd4, 16'd4, 16'h0200, 1'b0);
    chk("s2hi_nwr", wr_cnt - base_wr, 32'd16);

    // Fractional weights: scale 205 gives inv 319; horizontal then vertical
    mem[0] = 8'd0; mem[1] = 8'd100; mem[2] = 8'd200; mem[3] = 8'd40;
    run("s3h", 16'd4, 16'd1, 16'd205, 1'b0);
    chk("s3h_nwr", wr_cnt - base_wr, 32'd3);
    chk_wr("s3h", 0, 32'd0, 8'd0);
    chk_wr("s3h", 1, 32'd1, 8'd125);
    chk_wr("s3h", 2, 32'd2, 8'd121);
    run("s3v", 16'd1, 16'd4, 16'd205, 1'b0);
    chk("s3v_nwr", wr_cnt - base_wr, 32'd3);
    chk_wr("s3v", 1, 32'd1, 8'd125);
    chk_wr("s3v", 2, 32'd2, 8'd121);

    // Saturated image stays saturated
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    run("s4", 16'd4, 16'd4, 16'd205, 1'b0);
    chk("s4_nwr", wr_cnt - base_wr, 32'd9);
    for (int k = 0; k < 9; k++) chk_wr("s4", k, 32'(k), 8'hFF);
    chk_perf("s4", 9);

    // Empty source
    run("s5", 16'd0, 16'd4, 16'h0100, 1'b0);
    chk("s5_nwr", wr_cnt - base_wr, 32'd0);
    chk("s5_cycles", busy_cnt - base_busy, 32'd18);
    chk_perf("s5", 0);

    // Start re-asserted mid-run is ignored
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 10 + 3);
    run("s6", 16'd4, 16'd4, 16'h0100, 1'b1);
    chk("s6_nwr", wr_cnt - base_wr, 32'd16);
    chk("s6_cycles", busy_cnt - base_busy, 32'd130);
    chk_wr("s6", 15, 32'd15, mem[15]);
    chk_perf("s6", 16);

    // Reset after the fifth write aborts the run
    kick(16'd4, 16'd4, 16'h0100);
    for (int i = 0; i < 200 && (wr_cnt - base_wr) < 5; i++) tick(1);
    chk("s7_reach5", wr_cnt - base_wr, 32'd5);
    rst_sys = 1'b1;
    tick(2);
    chk("s7_rst_we",    32'(bif.out_we), 32'd0);
    chk("s7_rst_raddr", 32'(bif.in_raddr), 32'd0);
    chk("s7_rst_wr",    perf_mem_wr, 32'd0);
    rst_sys = 1'b0;
    tick(40);
    chk("s7_nwr_after", wr_cnt - base_wr, 32'd5);
    chk("s7_done", 32'(status_done), 32'd0);
    chk("s7_busy", 32'(status_busy), 32'd0);
    run("s7b", 16'd4, 16'd4, 16'h0100, 1'b0);
    chk("s7b_nwr", wr_cnt - base_wr, 32'd16);
    for (int k = 0; k < 16; k++) chk_wr("s7b", k, 32'(k), mem[k]);
    chk_perf("s7b", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bilinear_seq_core.md
BILINEAR_SEQ_CORE -- requirements
Module: bilinear_seq_core

Interface
REQ-001 SHALL have parameter AW, default 12, the BRAM address width in bits.
REQ-002 SHALL have a single clock and a synchronous, active-high reset: clk_sys (input, 1, system clock) and rst_sys (input, 1, reset).
REQ-003 SHALL have input start_pulse, 1 bit: start request; may be held high for several cycles.
REQ-004 SHALL have inputs cfg_in_w, cfg_in_h and cfg_scale_q88, 16 bits each: source width, source height, and scale in Q8.8 (0x0080..0x0100).
REQ-005 SHALL have outputs status_done and status_busy, 1 bit each.
REQ-006 SHALL have outputs perf_flops, perf_mem_rd and perf_mem_wr, 32 bits each: performance counters.
REQ-007 SHALL have input-image BRAM read ports: in_raddr (output, AW) and in_rdata (input, 8); in_rdata is valid one cycle after in_raddr.
REQ-008 SHALL have output-image BRAM write ports: out_waddr (output, AW), out_wdata (output, 8) and out_we (output, 1).

Function
REQ-009 SHALL start only on a start_pulse rising edge (0->1 relative to the previous cycle) while in IDLE or DONE.
REQ-010 SHALL latch cfg_* at start; cfg_* changes during a run SHALL have no effect.
REQ-011 SHALL implement these states and transitions:
- IDLE -> DIV on start
- DIV -> SETUP
- SETUP -> FETCH0 -> FETCH1 -> FETCH2 -> FETCH3 -> CAPT -> CALC -> WRITE
- WRITE -> FETCH0 for the next pixel, or WRITE -> DONE after the last pixel
- DONE -> DIV on start
REQ-012 SHALL, in DIV, compute inv_q88 = 65536 / scale_lat with the seq_div sub-module (17 cycles).
REQ-013 SHALL clamp scale_lat to 0x0080..0x0100 before the divide.
REQ-014 SHALL, in SETUP, compute out_w = max(1, (in_w*scale_lat)>>8) and out_h the same way from in_h.
REQ-015 SHALL, in SETUP, go directly to DONE with zero writes if in_w==0 or in_h==0.
REQ-016 SHALL compute source coordinates for output pixel (x,y) as follows:
- sx = x*inv_q88, a 24-bit Q8.8 value
- xi = sx>>8, fx = sx[7:0]
- x1 = min(xi+1, in_w-1); xi itself is clamped to in_w-1
- y, yi, fy and y1 follow the same rules against in_h
REQ-017 SHALL issue four reads in FETCH0..3, in the order (yi,xi), (yi,x1), (y1,xi), (y1,x1), with address = row*in_w + col truncated to AW bits; data SHALL be captured one cycle later.
REQ-018 SHALL compute pix = ((p00*(256-fx) + p01*fx)*(256-fy) + (p10*(256-fx) + p11*fx)*fy + 32768) >> 16, with 26-bit intermediates and the result saturated to 255.
REQ-019 SHALL, in WRITE, assert out_we for exactly one cycle with out_waddr = (y*out_w + x) mod 2^AW.
REQ-020 SHALL scan pixels in raster order, x fastest; each pixel takes 7 cycles.
REQ-021 SHALL hold status_busy=1 in every state except IDLE and DONE.
REQ-022 SHALL hold status_done=1 in DONE only; it stays high until the next start.
REQ-023 SHALL ignore start while busy; no restart and no counter change.
REQ-024 SHALL, per written pixel, add FLOPS_PER_PIXEL to perf_flops, 4 to perf_mem_rd and 1 to perf_mem_wr.
REQ-025 SHALL clear all three counters on an accepted start; counters SHALL hold their values in DONE.

Reset
REQ-026 SHALL, on rst_sys, enter IDLE with all outputs 0: status_*, perf_*, in_raddr, out_waddr, out_wdata, out_we.
REQ-027 SHALL, on reset mid-run, abort the same cycle; no out_we SHALL occur after reset.

Configuration
REQ-028 SHALL, with BILINEAR_PERF_EN defined, implement the REQ-024/025 counters.
REQ-029 SHALL, without BILINEAR_PERF_EN, tie perf_flops, perf_mem_rd and perf_mem_wr to 0 and instantiate no counter logic.

Structure
REQ-030 SHALL take the state enum, FLOPS_PER_PIXEL (=10), SCALE_MIN_Q88 (=128) and SCALE_MAX_Q88 (=256) from the shared package bilinear_pkg.
REQ-031 SHALL use one sub-module, seq_div: a 17-bit unsigned restoring divider with start/done handshake, one quotient bit per cycle.

Verification
REQ-032 SHALL cover these scenarios:
- 4x4 ramp, scale 0x0100 -> 16 writes identical to the input; mem_rd=64, mem_wr=16, flops=160.
- 4x4 ramp, scale 0x0080 -> out 2x2, inv=512; outputs equal input (0,0), (0,2), (2,0), (2,2).
- 4x4 all 0xFF, scale 205 -> out 3x3, all nine writes 0xFF.
- in_w=0 -> DONE with no out_we and counters 0; busy lasts DIV+SETUP cycles only.
- Start pulse re-asserted mid-run -> ignored; write count unchanged.
- rst_sys asserted at pixel 5 -> no further out_we; done=busy=0; a new start completes correctly.
